demux4_buf: RTL and testbench
=============================

Name: demux4_buf

Overview:
- Inverse of the ALU's 4:1 result selector.
- Takes one WIDTH-bit input stream with a valid/ready handshake and steers each accepted word, by a 2-bit select, into one of four output lanes (a, b, c, d).
- Each lane holds the word in a one-entry buffer with its own valid/ready handshake.
- Sits between the ALU result path and four independent consumers, such as display digits or register slots.

Parameters:
- WIDTH, 4, data width of input and of every lane.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  WIDTH  word to route
- in_sel  input  2  destination lane: 00=a, 01=b, 10=c, 11=d
- in_valid  input  1  in_data/in_sel valid this cycle
- in_ready  output  1  selected lane can accept this cycle
- out_data_a..out_data_d  output  WIDTH each  lane buffer contents
- out_valid_a..out_valid_d  output  1 each  lane buffer full
- out_ready_a..out_ready_d  input  1 each  consumer takes lane word this cycle

Behaviour:
- Interface is fixed: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: every out_valid_x=0 and every out_data_x=0, applied immediately on rst_n low.
  - Reset mid-transfer discards all buffered words.
  - No output is asserted until the first accepted word after rst_n deasserts.
- Each lane is a two-state FSM:
  - EMPTY -> FULL on push.
  - FULL -> EMPTY on pop without push.
  - FULL -> FULL on push and pop in the same cycle (replace).
- Push: in_valid & in_ready. The word goes to lane in_sel only; the other lanes are unaffected.
- Pop of lane x: out_valid_x & out_ready_x.
- in_ready = ~out_valid[in_sel] | out_ready[in_sel].
  - Combinational from in_sel and lane state; independent of in_valid.
  - A full lane being popped accepts a new word in the same cycle with no bubble.
- Latency: a word accepted on edge N appears on out_data_x/out_valid_x after edge N.
- out_data_x is only updated on a push to lane x. It holds its last value when the lane empties.
- Ordering: lanes are independent.
  - Backpressure on one lane stalls the input only while in_sel points at that lane.
  - Words for other lanes proceed.
- Producer rule (not enforced; checked by bench assertion): in_data and in_sel stay stable while in_valid=1 and in_ready=0.
- If in_valid=0, in_sel is don't-care and no state changes; pops still occur.
- With in_sel X/Z, in_ready is X and the bench must not drive it. RTL requires no X handling.
- Throughput: one word per cycle sustained when consumers are always ready.

Optional Feature:
- Macro: DEMUX4_AUTO_SEL_EN.
- Defined: adds input in_auto (1 bit) and output auto_ptr (2 bits, reset 00).
  - When in_auto=1, the destination lane is auto_ptr and in_sel is ignored.
  - auto_ptr increments mod 4 (11 wraps to 00) on each push made while in_auto=1.
  - auto_ptr holds while in_auto=0 or while stalled.
  - in_ready uses the effective lane.
- Not defined: no extra ports, and lane selection is always in_sel.

Decomposition:
- Shared package demux4_pkg:
  - Lane index constants LANE_A=2'b00, LANE_B=2'b01, LANE_C=2'b10, LANE_D=2'b11.
  - Default width constant, 4.
  - Lane state encoding: EMPTY=1'b0, FULL=1'b1.
- Natural sub-module: demux4_lane, the one-entry buffer with push/pop/replace. Instantiated four times; the top holds the select decode, in_ready mux and optional auto pointer.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> all out_valid=0, all out_data=0, no push. Release -> first push visible one cycle after its edge.
- Routing: all out_ready=1; push 4'h3 sel=00, 4'h7 sel=01, 4'hA sel=10, 4'hF sel=11 on consecutive cycles -> each lane shows only its word, one cycle later; in_ready stays 1.
- Backpressure: out_ready_b=0; push 4'h5 to b, then 4'h6 to b -> in_ready=0 on the second, lane b holds 4'h5. Raise out_ready_b -> pop and replace in one cycle, lane b=4'h6, out_valid_b stays 1.
- Lane independence: lane c full and stalled; push 4'h9 to a -> accepted immediately, lane c unchanged.
- Mid-operation reset: all lanes full; pulse rst_n low between edges -> all out_valid drop at once.
- Auto mode (macro defined): in_auto=1, push 4'h1..4'h5 -> lanes a,b,c,d,a in order, auto_ptr wraps 11->00. Stall on lane a -> auto_ptr holds at 00.

Source files
------------

// File: rtl/demux4_pkg.sv
// rtl/demux4_pkg.sv - shared constants and lane state encoding for demux4_buf
package demux4_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] LANE_A = 2'b00;
    localparam logic [1:0] LANE_B = 2'b01;
    localparam logic [1:0] LANE_C = 2'b10;
    localparam logic [1:0] LANE_D = 2'b11;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } lane_state_t;

endpackage

// File: rtl/demux4_lane.sv
// rtl/demux4_lane.sv - one-entry output buffer with push/pop/replace
//   clk, rst_n            clock, asynchronous active-low reset
//   push, push_data       write a word into the buffer this cycle
//   out_data, out_valid   buffered word and full flag
//   out_ready             consumer takes the word this cycle
module demux4_lane
    import demux4_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    lane_state_t      state_q;
    lane_state_t      state_d;
    logic [WIDTH-1:0] data_q;
    logic             pop;

    assign pop = (state_q == FULL) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A push while full only happens when the word is also popped,
    // so FULL+push is a replace and stays FULL.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (push)        state_d = FULL;
            FULL:  if (pop && !push) state_d = EMPTY;
            default:                state_d = EMPTY;
        endcase
    end

    // Data is only written on push and holds after the lane drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (push) begin
            data_q <= push_data;
        end
    end

    assign out_data  = data_q;
    assign out_valid = (state_q == FULL);

endmodule

// File: rtl/demux4_buf.sv
// rtl/demux4_buf.sv - 1:4 stream demux into four one-entry lane buffers
//   clk, rst_n                    clock, asynchronous active-low reset
//   in_data, in_sel, in_valid     input word, destination lane, valid
//   in_ready                      selected lane can accept this cycle
//   out_data_x, out_valid_x       lane x buffered word and full flag
//   out_ready_x                   consumer of lane x takes the word
//   DEMUX4_AUTO_SEL_EN adds in_auto (round-robin lane selection) and
//   auto_ptr (current round-robin lane).
module demux4_buf
    import demux4_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef DEMUX4_AUTO_SEL_EN
    input  logic             in_auto,
    output logic [1:0]       auto_ptr,
`endif
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data_a,
    output logic [WIDTH-1:0] out_data_b,
    output logic [WIDTH-1:0] out_data_c,
    output logic [WIDTH-1:0] out_data_d,
    output logic             out_valid_a,
    output logic             out_valid_b,
    output logic             out_valid_c,
    output logic             out_valid_d,
    input  logic             out_ready_a,
    input  logic             out_ready_b,
    input  logic             out_ready_c,
    input  logic             out_ready_d
);

    logic [1:0]       eff_sel;
    logic             push_en;
    logic [3:0]       lane_valid;
    logic [3:0]       lane_ready;
    logic [WIDTH-1:0] lane_data [4];

`ifdef DEMUX4_AUTO_SEL_EN
    logic [1:0] auto_ptr_q;

    // Advances only on an accepted word in auto mode; wraps naturally at 2 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_ptr_q <= LANE_A;
        end else if (push_en && in_auto) begin
            auto_ptr_q <= auto_ptr_q + 2'd1;
        end
    end

    assign auto_ptr = auto_ptr_q;
    assign eff_sel  = in_auto ? auto_ptr_q : in_sel;
`else
    assign eff_sel  = in_sel;
`endif

    assign lane_ready[LANE_A] = out_ready_a;
    assign lane_ready[LANE_B] = out_ready_b;
    assign lane_ready[LANE_C] = out_ready_c;
    assign lane_ready[LANE_D] = out_ready_d;

    // A lane being popped this cycle can take a new word with no bubble.
    assign in_ready = ~lane_valid[eff_sel] | lane_ready[eff_sel];
    assign push_en  = in_valid & in_ready;

    for (genvar i = 0; i < 4; i++) begin : g_lane
        demux4_lane #(
            .WIDTH(WIDTH)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .push     (push_en && (eff_sel == 2'(i))),
            .push_data(in_data),
            .out_data (lane_data[i]),
            .out_valid(lane_valid[i]),
            .out_ready(lane_ready[i])
        );
    end

    assign out_data_a  = lane_data[LANE_A];
    assign out_data_b  = lane_data[LANE_B];
    assign out_data_c  = lane_data[LANE_C];
    assign out_data_d  = lane_data[LANE_D];
    assign out_valid_a = lane_valid[LANE_A];
    assign out_valid_b = lane_valid[LANE_B];
    assign out_valid_c = lane_valid[LANE_C];
    assign out_valid_d = lane_valid[LANE_D];

endmodule

// File: tb/tb_demux4_buf.sv
// tb/tb_demux4_buf.sv - directed self-checking bench for demux4_buf
module tb_demux4_buf;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_data;
    logic [1:0] in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out_data_a, out_data_b, out_data_c, out_data_d;
    logic       out_valid_a, out_valid_b, out_valid_c, out_valid_d;
    logic       out_ready_a, out_ready_b, out_ready_c, out_ready_d;
`ifdef DEMUX4_AUTO_SEL_EN
    logic       in_auto;
    logic [1:0] auto_ptr;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    demux4_buf #(.WIDTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef DEMUX4_AUTO_SEL_EN
        .in_auto    (in_auto),
        .auto_ptr   (auto_ptr),
`endif
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data_a (out_data_a),
        .out_data_b (out_data_b),
        .out_data_c (out_data_c),
        .out_data_d (out_data_d),
        .out_valid_a(out_valid_a),
        .out_valid_b(out_valid_b),
        .out_valid_c(out_valid_c),
        .out_valid_d(out_valid_d),
        .out_ready_a(out_ready_a),
        .out_ready_b(out_ready_b),
        .out_ready_c(out_ready_c),
        .out_ready_d(out_ready_d)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] lane(input int l);
        case (l)
            0:       return {out_valid_a, out_data_a};
            1:       return {out_valid_b, out_data_b};
            2:       return {out_valid_c, out_data_c};
            default: return {out_valid_d, out_data_d};
        endcase
    endfunction

    task automatic check_lane(input string tag, input int l, input logic v, input logic [3:0] d);
        check($sformatf("%s_lane%0d", tag, l), 32'(lane(l)), 32'({v, d}));
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [3:0] d, input logic [3:0] rdy);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        {out_ready_d, out_ready_c, out_ready_b, out_ready_a} = rdy;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Producer-side rule: a stalled word must be held unchanged.
    logic       stall_q = 1'b0;
    logic [1:0] sel_q;
    logic [3:0] data_q;
    always @(posedge clk) begin
        if (rst_n && stall_q)
            check("stall_hold", 32'({in_valid, in_sel, in_data}), 32'({1'b1, sel_q, data_q}));
        stall_q <= rst_n & in_valid & ~in_ready;
        sel_q   <= in_sel;
        data_q  <= in_data;
    end

    initial begin
        rst_n = 1'b0;
`ifdef DEMUX4_AUTO_SEL_EN
        in_auto = 1'b0;
`endif
        // Reset held with a valid word present: nothing is pushed.
        drive(1'b1, 2'b00, 4'hF, 4'hF);
        tick;
        tick;
        for (int l = 0; l < 4; l++) check_lane("rst", l, 1'b0, 4'h0);

        // Routing at full rate, consumers always ready.
        rst_n = 1'b1;
        drive(1'b1, 2'b00, 4'h3, 4'hF);
        check("rdy_a", 32'(in_ready), 32'h1);
        check_lane("pre_push", 0, 1'b0, 4'h0);
        tick;
        check_lane("route_a", 0, 1'b1, 4'h3);
        check_lane("route_a", 1, 1'b0, 4'h0);
        drive(1'b1, 2'b01, 4'h7, 4'hF);
        check("rdy_b", 32'(in_ready), 32'h1);
        tick;
        check_lane("route_b", 0, 1'b0, 4'h3);
        check_lane("route_b", 1, 1'b1, 4'h7);
        drive(1'b1, 2'b10, 4'hA, 4'hF);
        check("rdy_c", 32'(in_ready), 32'h1);
        tick;
        check_lane("route_c", 1, 1'b0, 4'h7);
        check_lane("route_c", 2, 1'b1, 4'hA);
        check_lane("route_c", 3, 1'b0, 4'h0);
        drive(1'b1, 2'b11, 4'hF, 4'hF);
        check("rdy_d", 32'(in_ready), 32'h1);
        tick;
        check_lane("route_d", 2, 1'b0, 4'hA);
        check_lane("route_d", 3, 1'b1, 4'hF);

        // Backpressure on lane b, then pop and replace in one cycle.
        drive(1'b1, 2'b01, 4'h5, 4'b1101);
        check("bp_rdy_first", 32'(in_ready), 32'h1);
        tick;
        check_lane("bp_first", 1, 1'b1, 4'h5);
        check_lane("bp_first", 3, 1'b0, 4'hF);
        drive(1'b1, 2'b01, 4'h6, 4'b1101);
        check("bp_rdy_stall", 32'(in_ready), 32'h0);
        tick;
        check_lane("bp_stall", 1, 1'b1, 4'h5);
        check("bp_rdy_stall2", 32'(in_ready), 32'h0);
        drive(1'b1, 2'b01, 4'h6, 4'hF);
        check("bp_rdy_release", 32'(in_ready), 32'h1);
        tick;
        check_lane("bp_replace", 1, 1'b1, 4'h6);

        // Lane c stalled full; lane a still accepts at once.
        drive(1'b1, 2'b10, 4'h8, 4'b1011);
        tick;
        check_lane("ind_c", 2, 1'b1, 4'h8);
        check_lane("ind_b_drain", 1, 1'b0, 4'h6);
        drive(1'b1, 2'b00, 4'h9, 4'b1011);
        check("ind_rdy_a", 32'(in_ready), 32'h1);
        tick;
        check_lane("ind_a", 0, 1'b1, 4'h9);
        check_lane("ind_c_hold", 2, 1'b1, 4'h8);

        // Fill every lane with all consumers stalled.
        drive(1'b1, 2'b01, 4'h1, 4'h0);
        tick;
        drive(1'b1, 2'b11, 4'h2, 4'h0);
        tick;
        drive(1'b0, 2'b00, 4'h0, 4'h0);
        check("full_rdy_novalid", 32'(in_ready), 32'h0);
        tick;
        check_lane("full", 0, 1'b1, 4'h9);
        check_lane("full", 1, 1'b1, 4'h1);
        check_lane("full", 2, 1'b1, 4'h8);
        check_lane("full", 3, 1'b1, 4'h2);

        // Asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        for (int l = 0; l < 4; l++) check_lane("async_rst", l, 1'b0, 4'h0);
        tick;
        rst_n = 1'b1;
        drive(1'b0, 2'b00, 4'h0, 4'hF);
        tick;
        for (int l = 0; l < 4; l++) check_lane("post_rst", l, 1'b0, 4'h0);

`ifdef DEMUX4_AUTO_SEL_EN
        // Round-robin: lane a stalled so word 5 waits with the pointer at 00.
        in_auto = 1'b1;
        check("auto_ptr_rst", 32'(auto_ptr), 32'h0);
        drive(1'b1, 2'b11, 4'h1, 4'b1110);
        tick;
        check_lane("auto1", 0, 1'b1, 4'h1);
        check("auto_ptr1", 32'(auto_ptr), 32'h1);
        drive(1'b1, 2'b11, 4'h2, 4'b1110);
        tick;
        check_lane("auto2", 1, 1'b1, 4'h2);
        check("auto_ptr2", 32'(auto_ptr), 32'h2);
        drive(1'b1, 2'b11, 4'h3, 4'b1110);
        tick;
        check_lane("auto3", 2, 1'b1, 4'h3);
        check("auto_ptr3", 32'(auto_ptr), 32'h3);
        drive(1'b1, 2'b11, 4'h4, 4'b1110);
        tick;
        check_lane("auto4", 3, 1'b1, 4'h4);
        check("auto_ptr_wrap", 32'(auto_ptr), 32'h0);
        drive(1'b1, 2'b11, 4'h5, 4'b1110);
        check("auto_rdy_stall", 32'(in_ready), 32'h0);
        tick;
        check("auto_ptr_hold", 32'(auto_ptr), 32'h0);
        check_lane("auto_stall", 0, 1'b1, 4'h1);
        drive(1'b1, 2'b11, 4'h5, 4'hF);
        check("auto_rdy_release", 32'(in_ready), 32'h1);
        tick;
        check_lane("auto5", 0, 1'b1, 4'h5);
        check("auto_ptr5", 32'(auto_ptr), 32'h1);
        drive(1'b0, 2'b00, 4'h0, 4'hF);
        in_auto = 1'b0;
        tick;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
